i2c_reg_sequencer: RTL and testbench

Transaction controller in front of the I2C byte master. It turns a single host request into a complete register-level I2C transaction by driving the master's enable/addr/rw/data_wr inputs and tracking its busy handshake.
- Register write: START, dev+W, reg, data, STOP.
- Register read: START, dev+W, reg, repeated START, dev+R, data, NACK, STOP.
It returns read data and a status, and holds off new requests until the master is back in idle.

---
 rtl/i2c_reg_sequencer_if.sv | 22 ++
 rtl/i2c_reg_sequencer.sv | 167 ++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_sequencer_if.sv
// Handshake bundle between the register sequencer and the I2C byte master.
// The master modport is the sequencer side, and the slave modport is the byte-master side.
interface i2c_reg_sequencer_if;
    logic       i2c_enable;
    logic [6:0] i2c_addr;
    logic       i2c_rw;
    logic [7:0] i2c_data_wr;
    logic       i2c_busy;
    logic       i2c_ready;
    logic       i2c_ack_error;
    logic [7:0] i2c_data_rd;

    modport master (
        output i2c_enable, i2c_addr, i2c_rw, i2c_data_wr,
        input  i2c_busy, i2c_ready, i2c_ack_error, i2c_data_rd
    );

    modport slave (
        input  i2c_enable, i2c_addr, i2c_rw, i2c_data_wr,
        output i2c_busy, i2c_ready, i2c_ack_error, i2c_data_rd
    );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Register-level I2C transaction controller. A single host request becomes a
// complete register write or register read on the byte master. The controller
// tracks the master's busy edges and returns the read data with a status.
module i2c_reg_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned TO_W        = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  is_read,
    input  logic [6:0]            dev_addr,
    input  logic [7:0]            reg_addr,
    input  logic [7:0]            wr_data,
    output logic                  rdy,
    output logic [7:0]            rd_data,
    output logic                  done,
    output logic                  nack,
    output logic                  timeout,
    i2c_reg_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PH0, S_PH1, S_DRAIN, S_WAIT_IDLE, S_DONE
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam bit              TO_EN   = (TIMEOUT_CYC != 0);

    state_t          state, state_d;
    logic            busy_prev;
    logic            rise, fall, to_fire;
    logic            rd_lat, rd_lat_d;
    logic [7:0]      wdat_lat, wdat_lat_d;
    logic [TO_W-1:0] to_cnt, to_cnt_d;
    logic            en_q, en_d;
    logic [6:0]      addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [7:0]      dwr_q, dwr_d;
    logic [7:0]      rd_q, rd_d;
    logic            nack_q, nack_d;
    logic            to_q, to_d;

    assign rise    = bus.i2c_busy & ~busy_prev;
    assign fall    = ~bus.i2c_busy & busy_prev;
    assign to_fire = TO_EN && (to_cnt == TO_LAST) &&
                     (state inside {S_PH0, S_PH1, S_DRAIN, S_WAIT_IDLE});

    assign rdy             = (state == S_IDLE) & bus.i2c_ready;
    assign done            = (state == S_DONE);
    assign rd_data         = rd_q;
    assign nack            = nack_q;
    assign timeout         = to_q;
    assign bus.i2c_enable  = en_q;
    assign bus.i2c_addr    = addr_q;
    assign bus.i2c_rw      = rw_q;
    assign bus.i2c_data_wr = dwr_q;

    // Next-state and next-output decode for the transaction phases.
    always_comb begin
        // NOTE: every target gets a hold default first so no path infers a latch.
        state_d    = state;
        rd_lat_d   = rd_lat;
        wdat_lat_d = wdat_lat;
        en_d       = en_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        dwr_d      = dwr_q;
        rd_d       = rd_q;
        nack_d     = nack_q;
        to_d       = to_q;
        to_cnt_d   = to_cnt + TO_W'(1);

        // The watchdog restarts whenever the master shows progress.
        if (state == S_IDLE || rise || fall) begin
            to_cnt_d = '0;
        end

        if (state != S_IDLE && bus.i2c_ack_error) begin
            nack_d = 1'b1;
        end

        unique case (state)
            S_IDLE: begin
                if (req && bus.i2c_ready) begin
                    rd_lat_d   = is_read;
                    wdat_lat_d = wr_data;
                    addr_d     = dev_addr;
                    rw_d       = 1'b0;
                    dwr_d      = reg_addr;
                    en_d       = 1'b1;
                    nack_d     = 1'b0;
                    to_d       = 1'b0;
                    state_d    = S_PH0;
                end
            end
            S_PH0: begin
                // The master has taken dev+W/reg. Queue the second command now.
                if (rise) begin
                    if (rd_lat) rw_d  = 1'b1;
                    else        dwr_d = wdat_lat;
                    state_d = S_PH1;
                end
            end
            S_PH1: begin
                // The second command is running. Dropping enable makes it the last command.
                if (rise) begin
                    en_d    = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fall) begin
                    if (rd_lat) rd_d = bus.i2c_data_rd;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (bus.i2c_ready) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (to_fire) begin
            en_d    = 1'b0;
            to_d    = 1'b1;
            rd_d    = rd_q;
            state_d = S_DONE;
        end
    end

    // State and output registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state     <= S_IDLE;
            busy_prev <= 1'b0;
            rd_lat    <= 1'b0;
            wdat_lat  <= '0;
            to_cnt    <= '0;
            en_q      <= 1'b0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            dwr_q     <= '0;
            rd_q      <= '0;
            nack_q    <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state     <= state_d;
            busy_prev <= bus.i2c_busy;
            rd_lat    <= rd_lat_d;
            wdat_lat  <= wdat_lat_d;
            to_cnt    <= to_cnt_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            dwr_q     <= dwr_d;
            rd_q      <= rd_d;
            nack_q    <= nack_d;
            to_q      <= to_d;
        end
    end
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer. It includes a behavioural byte-master model
// that drives busy, ready, ack_error and data_rd, and logs the bytes it would put on the bus.
module tb_i2c_reg_sequencer;
    localparam int BYTE_CYC   = 10;
    localparam int LOG_START  = 256;
    localparam int LOG_RSTART = 257;
    localparam int LOG_STOP   = 258;

    logic       clk = 1'b0;
    logic       rst;
    logic       req = 1'b0;
    logic       is_read = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rdy;
    logic [7:0] rd_data;
    logic       done;
    logic       nack;
    logic       timeout;

    logic       m_busy, m_ready, m_ack_err;
    logic [7:0] m_data_rd;
    logic       m_dead   = 1'b0;
    logic [6:0] nack_dev = 7'h7F;
    logic [7:0] slave_rd = 8'h3C;
    int         bus_log[$];

    int total = 0;
    int bad   = 0;

    int         r_done_cnt;
    logic       r_nack, r_to, r_en_accept, r_en_rise2, r_expired;
    logic [7:0] r_rd;

    i2c_reg_sequencer_if bus();

    assign bus.i2c_busy      = m_busy;
    assign bus.i2c_ready     = m_ready;
    assign bus.i2c_ack_error = m_ack_err;
    assign bus.i2c_data_rd   = m_data_rd;

    i2c_reg_sequencer #(.TIMEOUT_CYC(100), .TO_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .is_read  (is_read),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .rdy      (rdy),
        .rd_data  (rd_data),
        .done     (done),
        .nack     (nack),
        .timeout  (timeout),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Byte-master model. It acts on negedges: it accepts a command, runs the address byte
    // when needed, runs one data byte, and then continues, issues a repeated START, or issues STOP.
    initial begin : master_model
        logic [6:0] c_addr;
        logic       c_rw;
        logic [7:0] c_data;
        logic       go, new_addr;
        m_busy = 1'b0; m_ready = 1'b1; m_ack_err = 1'b0; m_data_rd = '0;
        forever begin
            @(negedge clk);
            if (m_ready && bus.i2c_enable && !m_dead) begin
                m_ready = 1'b0; m_busy = 1'b1;
                c_addr = bus.i2c_addr; c_rw = bus.i2c_rw; c_data = bus.i2c_data_wr;
                bus_log.push_back(LOG_START);
                new_addr = 1'b1;
                go = 1'b1;
                while (go) begin
                    if (new_addr) begin
                        bus_log.push_back(int'({c_addr, c_rw}));
                        repeat (BYTE_CYC) @(negedge clk);
                        if (c_addr == nack_dev) begin
                            m_ack_err = 1'b1;
                            @(negedge clk);
                            m_ack_err = 1'b0;
                        end
                    end
                    if (c_rw) begin
                        m_data_rd = slave_rd;
                        bus_log.push_back(int'(slave_rd));
                    end else begin
                        bus_log.push_back(int'(c_data));
                    end
                    repeat (BYTE_CYC) @(negedge clk);
                    m_busy = 1'b0;
                    @(negedge clk);
                    if (bus.i2c_enable) begin
                        new_addr = (bus.i2c_addr != c_addr) || (bus.i2c_rw != c_rw);
                        if (new_addr) bus_log.push_back(LOG_RSTART);
                        c_addr = bus.i2c_addr; c_rw = bus.i2c_rw; c_data = bus.i2c_data_wr;
                        m_busy = 1'b1;
                    end else begin
                        repeat (2) @(negedge clk);
                        bus_log.push_back(LOG_STOP);
                        m_ready = 1'b1;
                        go = 1'b0;
                    end
                end
            end
        end
    end

    // Issue one request, then follow it to done. Sampling is done 1 time unit after each posedge.
    task automatic run_txn(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd);
        int   rises;
        int   after;
        logic bprev;
        r_done_cnt = 0; r_en_rise2 = 1'bx; r_expired = 1'b0;
        r_nack = 1'bx; r_to = 1'bx; r_rd = 'x;
        rises = 0; after = -1;
        bus_log.delete();
        @(negedge clk);
        is_read = rd; dev_addr = dev; reg_addr = ra; wr_data = wd; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        r_en_accept = bus.i2c_enable;
        bprev = m_busy;
        for (int c = 0; c < 3000 && after != 0; c++) begin
            @(posedge clk); #1;
            if (m_busy && !bprev) begin
                rises++;
                if (rises == 2) r_en_rise2 = bus.i2c_enable;
            end
            bprev = m_busy;
            if (done) begin
                r_done_cnt++;
                r_nack = nack; r_to = timeout; r_rd = rd_data;
                if (after < 0) after = 5;
            end
            if (after > 0) after--;
        end
        if (after != 0) r_expired = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rdy !== 1'b1)        begin bad++; $display("FAIL reset_rdy: got %b want 1", rdy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (nack !== 1'b0)       begin bad++; $display("FAIL reset_nack: got %b want 0", nack); end
        total++; if (timeout !== 1'b0)    begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        total++; if (rd_data !== 8'h00)   begin bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        total++; if (bus.i2c_enable !== 1'b0) begin bad++; $display("FAIL reset_enable: got %b want 0", bus.i2c_enable); end
        total++; if ({bus.i2c_addr, bus.i2c_rw, bus.i2c_data_wr} !== 16'h0000)
            begin bad++; $display("FAIL reset_bus_outs: got %h want 0000", {bus.i2c_addr, bus.i2c_rw, bus.i2c_data_wr}); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        int exp[$] = '{LOG_START, 'h90, 'h01, 'hA5, LOG_STOP};
        bit ok;
        run_txn(1'b0, 7'h48, 8'h01, 8'hA5);
        total++; if (r_en_accept !== 1'b1) begin bad++; $display("FAIL write_latency: enable=%b want 1", r_en_accept); end
        total++; if (r_expired || r_done_cnt != 1) begin bad++; $display("FAIL write_done: pulses=%0d want 1", r_done_cnt); end
        total++; if ({r_nack, r_to} !== 2'b00) begin bad++; $display("FAIL write_status: nack/timeout=%b want 00", {r_nack, r_to}); end
        total++; if (r_en_rise2 !== 1'b0) begin bad++; $display("FAIL write_enable_after_rise2: got %b want 0", r_en_rise2); end
        ok = (bus_log.size() == exp.size());
        if (ok) foreach (exp[i]) if (bus_log[i] != exp[i]) ok = 0;
        total++; if (!ok) begin bad++; $display("FAIL write_bus: got %p want %p", bus_log, exp); end
    endtask

    task automatic test_read();
        int exp[$] = '{LOG_START, 'h90, 'h00, LOG_RSTART, 'h91, 'h3C, LOG_STOP};
        bit ok;
        run_txn(1'b1, 7'h48, 8'h00, 8'h00);
        total++; if (r_expired || r_done_cnt != 1) begin bad++; $display("FAIL read_done: pulses=%0d want 1", r_done_cnt); end
        total++; if (r_rd !== 8'h3C) begin bad++; $display("FAIL read_data: got %h want 3c", r_rd); end
        total++; if ({r_nack, r_to} !== 2'b00) begin bad++; $display("FAIL read_status: nack/timeout=%b want 00", {r_nack, r_to}); end
        total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL read_data_held: got %h want 3c", rd_data); end
        ok = (bus_log.size() == exp.size());
        if (ok) foreach (exp[i]) if (bus_log[i] != exp[i]) ok = 0;
        total++; if (!ok) begin bad++; $display("FAIL read_bus: got %p want %p", bus_log, exp); end
    endtask

    task automatic test_nack();
        int exp[$] = '{LOG_START, 'h90, 'h10, 'h55, LOG_STOP};
        bit ok;
        nack_dev = 7'h48;
        run_txn(1'b0, 7'h48, 8'h10, 8'h55);
        nack_dev = 7'h7F;
        total++; if (r_expired || r_done_cnt != 1) begin bad++; $display("FAIL nack_done: pulses=%0d want 1", r_done_cnt); end
        total++; if (r_nack !== 1'b1) begin bad++; $display("FAIL nack_flag: got %b want 1", r_nack); end
        total++; if (r_to !== 1'b0) begin bad++; $display("FAIL nack_timeout: got %b want 0", r_to); end
        total++; if (r_rd !== 8'h3C) begin bad++; $display("FAIL nack_rd_unchanged: got %h want 3c", r_rd); end
        total++; if (nack !== 1'b1) begin bad++; $display("FAIL nack_held: got %b want 1", nack); end
        ok = (bus_log.size() == exp.size());
        if (ok) foreach (exp[i]) if (bus_log[i] != exp[i]) ok = 0;
        total++; if (!ok) begin bad++; $display("FAIL nack_bus: got %p want %p", bus_log, exp); end
    endtask

    task automatic test_timeout();
        int early;
        m_dead = 1'b1;
        early = 0;
        @(negedge clk);
        is_read = 1'b1; dev_addr = 7'h22; reg_addr = 8'h07; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        total++; if (bus.i2c_enable !== 1'b1) begin bad++; $display("FAIL to_start_enable: got %b want 1", bus.i2c_enable); end
        total++; if (nack !== 1'b0) begin bad++; $display("FAIL to_nack_cleared: got %b want 0", nack); end
        for (int k = 1; k < 100; k++) begin
            @(posedge clk); #1;
            if (bus.i2c_enable !== 1'b1 || done !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL to_early_abort: bad cycles=%0d want 0", early); end
        @(posedge clk); #1;
        total++; if ({bus.i2c_enable, done, timeout} !== 3'b011)
            begin bad++; $display("FAIL to_abort: enable/done/timeout=%b want 011", {bus.i2c_enable, done, timeout}); end
        total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL to_rd_unchanged: got %h want 3c", rd_data); end
        @(posedge clk); #1;
        total++; if ({rdy, done, timeout} !== 3'b101)
            begin bad++; $display("FAIL to_back_idle: rdy/done/timeout=%b want 101", {rdy, done, timeout}); end
        m_dead = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   exp[$] = '{LOG_START, 'h90, 'h02, 'h11, LOG_STOP, LOG_START, 'h90, 'h02, 'h11, LOG_STOP};
        int   dones, starts, extra;
        logic en_prev;
        bit   ok;
        dones = 0; starts = 0; extra = 0; en_prev = 1'b0;
        bus_log.delete();
        @(negedge clk);
        is_read = 1'b0; dev_addr = 7'h48; reg_addr = 8'h02; wr_data = 8'h11; req = 1'b1;
        for (int c = 0; c < 3000 && dones < 2; c++) begin
            @(posedge clk); #1;
            if (bus.i2c_enable && !en_prev) begin
                total++;
                if (starts != dones) begin bad++; $display("FAIL b2b_overlap: start %0d with dones=%0d", starts, dones); end
                starts++;
            end
            en_prev = bus.i2c_enable;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    @(posedge clk); #1;
                    total++;
                    if ({bus.i2c_enable, rdy} !== 2'b01)
                        begin bad++; $display("FAIL b2b_done_req_ignored: enable/rdy=%b want 01", {bus.i2c_enable, rdy}); end
                    en_prev = bus.i2c_enable;
                end
            end
        end
        req = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.i2c_enable) extra++;
        end
        total++; if (dones != 2 || starts != 2) begin bad++; $display("FAIL b2b_count: dones=%0d starts=%0d want 2 2", dones, starts); end
        total++; if (extra != 0) begin bad++; $display("FAIL b2b_third_start: enable cycles=%0d want 0", extra); end
        ok = (bus_log.size() == exp.size());
        if (ok) foreach (exp[i]) if (bus_log[i] != exp[i]) ok = 0;
        total++; if (!ok) begin bad++; $display("FAIL b2b_bus: got %p want %p", bus_log, exp); end
    endtask

    task automatic test_reset_mid_read();
        int exp[$] = '{LOG_START, 'h90, 'h05, 'h77, LOG_STOP};
        bit   ok, seen_en, in_drain, idle_ok;
        seen_en = 0; in_drain = 0; idle_ok = 0;
        @(negedge clk);
        is_read = 1'b1; dev_addr = 7'h48; reg_addr = 8'h00; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        for (int c = 0; c < 3000 && !in_drain; c++) begin
            @(posedge clk); #1;
            if (bus.i2c_enable) seen_en = 1;
            else if (seen_en)   in_drain = 1;
        end
        total++; if (!in_drain) begin bad++; $display("FAIL rst_reach_drain: not reached"); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.i2c_enable !== 1'b0) begin bad++; $display("FAIL rst_enable: got %b want 0", bus.i2c_enable); end
        total++; if (rdy !== m_ready) begin bad++; $display("FAIL rst_rdy: got %b want %b", rdy, m_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
        rst = 1'b1;
        for (int c = 0; c < 3000 && !idle_ok; c++) begin
            @(posedge clk); #1;
            if (m_ready) idle_ok = 1;
        end
        total++; if (!idle_ok) begin bad++; $display("FAIL rst_master_idle: master never idle"); end
        run_txn(1'b0, 7'h48, 8'h05, 8'h77);
        total++; if (r_expired || r_done_cnt != 1) begin bad++; $display("FAIL rst_write_done: pulses=%0d want 1", r_done_cnt); end
        total++; if ({r_nack, r_to} !== 2'b00) begin bad++; $display("FAIL rst_write_status: nack/timeout=%b want 00", {r_nack, r_to}); end
        ok = (bus_log.size() == exp.size());
        if (ok) foreach (exp[i]) if (bus_log[i] != exp[i]) ok = 0;
        total++; if (!ok) begin bad++; $display("FAIL rst_write_bus: got %p want %p", bus_log, exp); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
